// File: rtl/disp_share_sched.sv
// Shares the 6-digit multiplexed seven-segment display between a default
// requester and a priority requester; also owns digit scan and hex decode.
module disp_share_sched #(
    parameter int CLK_DIV    = 50000,
    parameter int HOLD_TICKS = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [23:0] data0,
    output logic        gnt0,
    input  logic        req1,
    input  logic [23:0] data1,
    output logic        gnt1,
    output logic        busy,
    output logic [2:0]  sel,
    output logic [7:0]  seg
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hold;
    logic [23:0]   frame;
    logic [23:0]   frame_nxt;
    logic [2:0]    sel_nxt;
    logic          tick;
    logic          wrap;
    logic          entry;

    function automatic logic [7:0] hex7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign tick = (cnt == CW'(CLK_DIV - 1));
    assign wrap = tick && (sel == 3'd5);

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (req1)      nxt = OWN1;
                else if (req0) nxt = OWN0;
            end
            OWN0: begin
                if (req1)       nxt = OWN1;
                else if (!req0) nxt = IDLE;
            end
            OWN1: begin
                if (hold == '0) begin
                    if (req1)      nxt = OWN1;
                    else if (req0) nxt = OWN0;
                    else           nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Reload on a change of owner, or at frame wrap so a frame never tears.
    always_comb begin
        entry     = (nxt != state) && (nxt != IDLE);
        frame_nxt = frame;
        if ((entry || wrap) && nxt != IDLE)
            frame_nxt = (nxt == OWN1) ? data1 : data0;
        sel_nxt = sel;
        if (tick)
            sel_nxt = (sel == 3'd5) ? 3'd0 : sel + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            cnt   <= '0;
            sel   <= 3'd0;
            hold  <= '0;
            frame <= 24'h0;
            seg   <= 8'hFF;
        end else begin
            state <= nxt;
            gnt0  <= (nxt == OWN0);
            gnt1  <= (nxt == OWN1);
            cnt   <= tick ? '0 : cnt + CW'(1);
            sel   <= sel_nxt;
            frame <= frame_nxt;
            if (nxt == OWN1 && state != OWN1)
                hold <= HW'(HOLD_TICKS);
            else if (state == OWN1 && tick && hold != '0)
                hold <= hold - HW'(1);
            if (nxt == IDLE)
                seg <= 8'hFF;
            else
                seg <= hex7(frame_nxt[{sel_nxt, 2'b00} +: 4]);
        end
    end

    assign busy = gnt0 | gnt1;

endmodule

// File: tb/tb_disp_share_sched.sv
// Directed vector bench for disp_share_sched with CLK_DIV=4, HOLD_TICKS=3.
module tb_disp_share_sched;

    logic        clk;
    logic        rst;
    logic        req0;
    logic        req1;
    logic [23:0] data0;
    logic [23:0] data1;
    logic        gnt0;
    logic        gnt1;
    logic        busy;
    logic [2:0]  sel;
    logic [7:0]  seg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          n;
        logic        rst;
        logic        r0;
        logic        r1;
        logic [23:0] d0;
        logic [23:0] d1;
        logic        g0;
        logic        g1;
        logic [2:0]  sel;
        logic [7:0]  seg;
    } vec_t;

    vec_t tbl[$];

    disp_share_sched #(.CLK_DIV(4), .HOLD_TICKS(3)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .data1(data1), .gnt1(gnt1),
        .busy(busy), .sel(sel), .seg(seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grants must be mutually exclusive on every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (gnt0 && gnt1) begin
                errors++;
                $display("FAIL excl gnt0=%b gnt1=%b required not both", gnt0, gnt1);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input int n, input logic r,
                       input logic r0, input logic r1,
                       input logic [23:0] d0, input logic [23:0] d1,
                       input logic g0, input logic g1,
                       input logic [2:0] s, input logic [7:0] sg);
        vec_t v;
        v.name = nm; v.n = n; v.rst = r; v.r0 = r0; v.r1 = r1;
        v.d0 = d0; v.d1 = d1; v.g0 = g0; v.g1 = g1; v.sel = s; v.seg = sg;
        tbl.push_back(v);
    endtask

    localparam logic [23:0] A = 24'h543210;
    localparam logic [23:0] B = 24'hABCDEF;
    localparam logic [23:0] F = 24'hFFFFFF;

    initial begin
        // e = clock edges since reset release; sel = (e/4) mod 6
        add("idle_e3",   3,  0, 0, 0, A, B, 0, 0, 3'd0, 8'hFF);
        add("idle_e4",   1,  0, 0, 0, A, B, 0, 0, 3'd1, 8'hFF);
        add("idle_e8",   4,  0, 0, 0, A, B, 0, 0, 3'd2, 8'hFF);
        add("idle_wrap", 16, 0, 0, 0, A, B, 0, 0, 3'd0, 8'hFF);
        add("idle_e28",  4,  0, 0, 0, A, B, 0, 0, 3'd1, 8'hFF);
        add("own0_ent",  1,  0, 1, 0, A, B, 1, 0, 3'd1, 8'hF9);
        add("own0_d2",   3,  0, 1, 0, A, B, 1, 0, 3'd2, 8'hA4);
        add("own0_d3",   4,  0, 1, 0, A, B, 1, 0, 3'd3, 8'hB0);
        add("tear_d4",   4,  0, 1, 0, F, B, 1, 0, 3'd4, 8'h99);
        add("tear_d5",   4,  0, 1, 0, F, B, 1, 0, 3'd5, 8'h92);
        add("tear_e47",  3,  0, 1, 0, F, B, 1, 0, 3'd5, 8'h92);
        add("tear_wrap", 1,  0, 1, 0, F, B, 1, 0, 3'd0, 8'h8E);
        add("tear_e52",  4,  0, 1, 0, F, B, 1, 0, 3'd1, 8'h8E);
        add("rel0",      1,  0, 0, 0, A, B, 0, 0, 3'd1, 8'hFF);
        add("both_req",  1,  0, 1, 1, A, B, 0, 1, 3'd1, 8'h86);
        add("own1_keep", 11, 0, 1, 1, A, B, 0, 1, 3'd4, 8'h83);
        add("own1_idle", 1,  0, 0, 0, A, B, 0, 0, 3'd4, 8'hFF);
        add("pre_own0",  1,  0, 1, 0, A, B, 1, 0, 3'd4, 8'h99);
        add("preempt",   1,  0, 1, 1, A, B, 0, 1, 3'd5, 8'h88);
        add("hold_wrap", 4,  0, 1, 0, A, B, 0, 1, 3'd0, 8'h8E);
        add("hold_last", 8,  0, 1, 0, A, B, 0, 1, 3'd2, 8'hA1);
        add("back_own0", 1,  0, 1, 0, A, B, 1, 0, 3'd2, 8'hA4);
        add("own1_again",1,  0, 0, 1, A, B, 0, 1, 3'd2, 8'hA1);
        add("mid_rst",   1,  1, 0, 1, A, B, 0, 0, 3'd0, 8'hFF);
        add("rst_ent1",  1,  0, 0, 1, A, B, 0, 1, 3'd0, 8'h8E);
        add("rst_hold",  11, 0, 0, 0, A, B, 0, 1, 3'd3, 8'hC6);
        add("rst_rel",   1,  0, 0, 0, A, B, 0, 0, 3'd3, 8'hFF);

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = 24'h0; data1 = 24'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", {7'd0, gnt0}, 8'h00);
        chk("rst_gnt1", {7'd0, gnt1}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_sel",  {5'd0, sel},  8'h00);
        chk("rst_seg",  seg,          8'hFF);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; req0 = tbl[i].r0; req1 = tbl[i].r1;
            data0 = tbl[i].d0; data1 = tbl[i].d1;
            repeat (tbl[i].n) @(posedge clk);
            @(negedge clk);
            chk({tbl[i].name, ".gnt0"}, {7'd0, gnt0}, {7'd0, tbl[i].g0});
            chk({tbl[i].name, ".gnt1"}, {7'd0, gnt1}, {7'd0, tbl[i].g1});
            chk({tbl[i].name, ".busy"}, {7'd0, busy},
                {7'd0, tbl[i].g0 | tbl[i].g1});
            chk({tbl[i].name, ".sel"},  {5'd0, sel},  {5'd0, tbl[i].sel});
            chk({tbl[i].name, ".seg"},  seg,          tbl[i].seg);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_share_sched.md
# disp_share_sched

Display scheduler that owns the 6-digit multiplexed seven-segment display and shares it between two requesters: a low-priority default source (e.g. the key-pulse counter) and a high-priority event source (e.g. alarm/overflow message). It arbitrates ownership with a request/grant handshake and a minimum hold time for the high-priority owner. It also generates the digit-scan sequence and hex decode, replacing the separate scan-clock divider.

## Interface
- CLK_DIV, 50000: system clocks per scan tick (50 MHz -> 1 kHz digit rate); must be >= 2.
- HOLD_TICKS, 2000: minimum scan ticks requester 1 keeps the display once granted; 0 = no minimum.

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req0  in  1  low-priority display request, level.
- data0  in  24  six hex digits from requester 0; digit k = data0[4k+3:4k].
- gnt0  out  1  requester 0 owns display.
- req1  in  1  high-priority display request, level.
- data1  in  24  six hex digits from requester 1, same packing.
- gnt1  out  1  requester 1 owns display.
- busy  out  1  high when any requester owns the display.
- sel  out  3  binary digit index 0..5 to the external 3-8 decoder.
- seg  out  8  active-low segments, seg[7]=dp (always 1/off), seg[6:0]=g..a.

## Operation
- Scan: free-running tick counter 0..CLK_DIV-1; tick = 1 when counter = CLK_DIV-1. On tick sel advances 0,1,2,3,4,5,0. Scan never stops or resets on ownership change.
- Frame buffer: 24-bit register holding the displayed digits. Loaded from owner's data on (a) ownership entry, (b) each tick where sel wraps 5->0 (tear-free refresh). (a) and (b) coinciding: single load from new owner.
- Decode: hex of frame[4*sel+3:4*sel]; 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E. In IDLE seg = FF (blank).
- FSM states IDLE, OWN0, OWN1:
  - IDLE: req1 -> OWN1; else req0 -> OWN0; else stay. req0 and req1 together -> OWN1.
  - OWN0: req1 -> OWN1 (preemption, immediate); else !req0 -> IDLE; else stay.
  - OWN1: on entry hold counter loads HOLD_TICKS; decrements on each tick, saturates at 0. While hold > 0 stay regardless of requests. When hold = 0: req1 -> stay; else req0 -> OWN0; else IDLE.
- gnt0 = (state==OWN0), gnt1 = (state==OWN1), busy = gnt0|gnt1; gnt0/gnt1 never both high.
- Requester 1 dropping req1 during hold keeps ownership; frame continues refreshing from data1 at frame wrap.

## Timing
- Reset values: state IDLE, gnt0=0, gnt1=0, busy=0, sel=0, seg=FF, tick counter 0, hold counter 0, frame 0.
- Request-to-grant latency: 1 clk (req sampled at edge N, gnt high after edge N). Release: gnt drops 1 clk after the qualifying edge.
- Preemption OWN0->OWN1: gnt0 falls and gnt1 rises on the same edge; no idle cycle.
- sel and seg registered on the same edge; seg always reflects current sel and current frame; frame load on entry is visible in seg the edge after entry.
- First tick after reset occurs at clock CLK_DIV (counter reaches CLK_DIV-1).
- OWN1 minimum residency: HOLD_TICKS ticks counted after entry; with HOLD_TICKS=0 exit is evaluated the clk after entry.
- rst mid-operation: all registers return to reset values on that edge, including hold count; grants drop immediately.

## Test plan
- Reset then idle, CLK_DIV=4: sel steps 0..5 every 4 clks, wraps to 0 after 5; seg stays FF; gnt0=gnt1=busy=0.
- req0=1, data0=0x543210: gnt0 high 1 clk later; sel=k shows C0,F9,A4,B0,99,92; change data0 mid-frame to 0xFFFFFF -> display changes only after sel wrap 5->0.
- req0 and req1 asserted same clk in IDLE: gnt1=1, gnt0=0; seg from data1.
- OWN0 with req1 pulse of 1 clk, HOLD_TICKS=3: gnt0->0 and gnt1->1 same edge; gnt1 held through 3 ticks, then returns to OWN0 (req0 still high) within 1 clk after the 3rd tick.
- OWN1, hold expired, req1 and req0 dropped: IDLE next clk, seg=FF, sel continues counting unchanged.
- rst asserted during OWN1 hold: next edge gnt1=0, busy=0, sel=0, seg=FF; after release, req1 restarts full hold.
